led_chaser_param: RTL

- Parametrised successor to the board's fixed 4-LED, 1 s/step rotating-LED loop.
- Generalised in LED count and step period.
- Adds run/pause, four selectable pattern modes, and step/wrap status pulses.
- Sits directly behind the board clock and drives the LED pins. Status pulses are available to other on-board logic, e.g. a buzzer or a segment display.

---
 rtl/led_chaser_param.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/led_chaser_param.sv
// Parametrised LED chaser: rotate-left/right, ping-pong and fill patterns with run/pause and step/wrap pulses.
// Optional brightness PWM on the LED drive is enabled by defining LED_CHASER_PWM_EN.
module led_chaser_param #(
    parameter int unsigned LED_NUM     = 4,
    parameter int unsigned STEP_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
`ifdef LED_CHASER_PWM_EN
    input  logic [3:0]         bright,
`endif
    output logic [LED_NUM-1:0] led,
    output logic               step,
    output logic               wrap
);

    localparam int unsigned    IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LED_NUM - 1);

    typedef enum logic [1:0] {
        MODE_ROL  = 2'b00,
        MODE_ROR  = 2'b01,
        MODE_PING = 2'b10,
        MODE_FILL = 2'b11
    } mode_e;

    // ST_IDLE: waiting for the first step after reset/restart; UP/DOWN carry ping-pong direction
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         mode_q;
    logic [LED_NUM-1:0] pattern_q, pattern_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;
    logic [IDX_W-1:0]   nidx;
    logic               ndir_down;

    function automatic logic [LED_NUM-1:0] pat(input logic [1:0] m, input logic [IDX_W-1:0] i);
        logic [LED_NUM-1:0] p;
        p = '0;
        for (int b = 0; b < LED_NUM; b++) begin
            if (m == MODE_FILL) p[b] = (IDX_W'(b) <= i);
            else                p[b] = (IDX_W'(b) == i);
        end
        return p;
    endfunction

    // Candidate next position and ping-pong direction for the current mode
    always_comb begin
        nidx      = idx_q;
        ndir_down = (state_q == ST_DOWN);
        if (LED_NUM > 1) begin
            case (mode_q)
                MODE_ROR: nidx = (idx_q == '0) ? LAST : idx_q - 1'b1;
                MODE_PING: begin
                    if (state_q == ST_DOWN) nidx = idx_q - 1'b1;
                    else                    nidx = idx_q + 1'b1;
                    if (nidx == LAST)       ndir_down = 1'b1;
                    else if (nidx == '0)    ndir_down = 1'b0;
                end
                default: nidx = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            endcase
        end
    end

    // Next-state: restart > pause > step > count
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        pattern_d = pattern_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        if (mode != mode_q) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            idx_d     = '0;
            pattern_d = '0;
        end else if (!en) begin
            state_d = state_q;
        end else if (timer_q == TERM) begin
            timer_d = '0;
            step_d  = 1'b1;
            if (state_q == ST_IDLE) begin
                state_d   = ST_UP;
                idx_d     = '0;
                pattern_d = pat(mode_q, '0);
            end else begin
                state_d   = ndir_down ? ST_DOWN : ST_UP;
                idx_d     = nidx;
                pattern_d = pat(mode_q, nidx);
                wrap_d    = (nidx == '0);
            end
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            mode_q    <= mode;
            pattern_q <= '0;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            mode_q    <= mode;
            pattern_q <= pattern_d;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
        end
    end

    assign step = step_q;
    assign wrap = wrap_q;

`ifdef LED_CHASER_PWM_EN
    logic [3:0]         pwm_cnt_q;
    logic               pwm_on;
    logic [LED_NUM-1:0] led_q;

    assign pwm_on = (pwm_cnt_q < bright) || (bright == 4'hF);

    // Free-running PWM; gates the registered LED drive without touching the pattern
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            led_q     <= pattern_d & {LED_NUM{pwm_on}};
        end
    end

    assign led = led_q;
`else
    assign led = pattern_q;
`endif

endmodule
